fifo_read_ctrl: RTL

//  Read-side controller for the FIFO. It is the consumer end of the 6-bit write pointer.
//  It compares its own 6-bit read pointer against the write pointer to detect empty and

---
 rtl/fifo_pkg.sv | 11 +
 rtl/fifo_read_ctrl_if.sv | 28 ++
 rtl/rd_skid_buf.sv | 61 ++++++
 rtl/fifo_read_ctrl.sv | 69 ++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO package: pointer geometry used by both the read and write controllers.
package fifo_pkg;

   localparam int PTR_W  = 6;
   localparam int ADDR_W = PTR_W - 1;
   localparam int DEPTH  = 2 ** ADDR_W;

   typedef logic [PTR_W-1:0]  ptr_t;
   typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/fifo_read_ctrl_if.sv
// Read-side bus of the FIFO: pointer exchange with the writer, storage read port
// and the valid/ready output toward the consumer.
interface fifo_read_ctrl_if #(parameter int WIDTH = 8);
   import fifo_pkg::*;

   ptr_t             wr_ptr;
   logic             rd_en;
   addr_t            rd_addr;
   logic [WIDTH-1:0] mem_rdata;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;
   ptr_t             rd_ptr;
   logic             empty;
   ptr_t             level;
   logic             underflow;

   modport master (
      input  wr_ptr, mem_rdata, dout_ready,
      output rd_en, rd_addr, dout, dout_valid, rd_ptr, empty, level, underflow
   );

   modport slave (
      output wr_ptr, mem_rdata, dout_ready,
      input  rd_en, rd_addr, dout, dout_valid, rd_ptr, empty, level, underflow
   );

endinterface

// File: rtl/rd_skid_buf.sv
// Two-entry output queue in front of the consumer; head_q is the presented word.
module rd_skid_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic [1:0]       occ,
   output logic             valid
);

   logic [1:0]       occ_q, occ_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic             pop_eff;

   // Pop first (tail moves to head), then push lands in the first free slot.
   always_comb begin
      occ_d   = occ_q;
      head_d  = head_q;
      tail_d  = tail_q;
      pop_eff = pop & (occ_q != 2'd0);
      if (pop_eff) begin
         head_d = tail_q;
         occ_d  = occ_q - 2'd1;
      end
      if (push) begin
         if (occ_d == 2'd0) begin
            head_d = data_in;
         end else begin
            tail_d = data_in;
         end
         occ_d = occ_d + 2'd1;
      end
   end

   // Queue state registers; reset empties the queue and zeroes the head word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q  <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         occ_q  <= occ_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   assign data_out = head_q;
   assign occ      = occ_q;
   assign valid    = (occ_q != 2'd0);

   // The upstream credit rule must never deliver a word into a full queue.
   assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && (occ_q == 2'd2)));

endmodule

// File: rtl/fifo_read_ctrl.sv
// FIFO read controller: read pointer, credit-based read issue into a 2-entry
// output queue, empty/level against the writer pointer, sticky underflow.
module fifo_read_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              clear,
   fifo_read_ctrl_if.master  bus
);
   import fifo_pkg::*;

   ptr_t             rd_ptr_q, rd_ptr_d;
   logic             pend_q, pend_d;
   logic             underflow_q, underflow_d;
   logic             rd_en;
   logic             pop;
   logic             empty;
   ptr_t             level;
   logic [2:0]       credit;
   logic [1:0]       occ;
   logic             buf_valid;
   logic [WIDTH-1:0] buf_dout;

   // Issue a read only if the word will have a queue slot when it returns.
   always_comb begin
      empty       = (rd_ptr_q == bus.wr_ptr);
      level       = bus.wr_ptr - rd_ptr_q;
      pop         = buf_valid & bus.dout_ready;
      credit      = {1'b0, occ} + {2'b00, pend_q} - {2'b00, pop};
      rd_en       = clear & !empty & (credit < 3'd2);
      rd_ptr_d    = rd_ptr_q + ptr_t'(rd_en);
      pend_d      = rd_en;
      underflow_d = underflow_q | (bus.dout_ready & !buf_valid);
   end

   // Pointer, in-flight read flag and sticky underflow; reset drops any in-flight read.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         rd_ptr_q    <= '0;
         pend_q      <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         pend_q      <= pend_d;
         underflow_q <= underflow_d;
      end
   end

   rd_skid_buf #(.WIDTH(WIDTH)) u_skid (
      .clk      (clk),
      .rst_n    (clear),
      .push     (pend_q),
      .pop      (pop),
      .data_in  (bus.mem_rdata),
      .data_out (buf_dout),
      .occ      (occ),
      .valid    (buf_valid)
   );

   assign bus.rd_en      = rd_en;
   assign bus.rd_addr    = rd_ptr_q[PTR_W-2:0];
   assign bus.dout       = buf_dout;
   assign bus.dout_valid = buf_valid;
   assign bus.rd_ptr     = rd_ptr_q;
   assign bus.empty      = empty;
   assign bus.level      = level;
   assign bus.underflow  = underflow_q;

endmodule
